cache_fill_arb: RTL

Parametrised miss-fill controller shared by the instruction and data caches. It arbitrates block-fill requests from NUM_CH cache channels onto one single-ported, fixed-latency main memory, streams one block per grant, and writes the returned words into the requesting cache. It also gives a single-cycle write-through port priority access while idle. It generalises the existing two-requester memory FSM (i/d busy) to N channels, configurable block size, memory latency and arbitration mode.

---
 rtl/cache_fill_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/cache_fill_arb.sv | 117 +++++++++++
 3 files changed

// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared types and helpers for the cache miss-fill arbiter
package cache_fill_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int off_bits(input int words, input int data_w);
        return $clog2(words * data_w / 8);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: fixed-priority or round-robin request picker with one-hot and index grant
module rr_arbiter
    import cache_fill_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int MODE   = ARB_FIXED,
    localparam int CW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              accept,
    output logic [NUM_CH-1:0] grant,
    output logic [CW-1:0]     grant_idx
);

    logic [CW-1:0] last;
    logic [CW-1:0] c;
    logic          found;

    // round-robin search starts just after the previous winner and wraps
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = '0;
        for (int j = 0; j < NUM_CH; j++) begin
            c = (MODE == ARB_RR) ? CW'((int'(last) + 1 + j) % NUM_CH) : CW'(j);
            if (!found && req[c]) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            last <= CW'(NUM_CH - 1);
        else if (accept)
            last <= grant_idx;
    end

endmodule

// File: rtl/cache_fill_arb.sv
// cache_fill_arb: arbitrates block fills from NUM_CH caches onto one fixed-latency memory
module cache_fill_arb
    import cache_fill_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WORDS    = 8,
    parameter int MEM_LAT  = 4,
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_CH-1:0]          miss_req,
    input  logic [NUM_CH*ADDR_W-1:0]   miss_addr,
    output logic [NUM_CH-1:0]          fsm_busy,
    output logic [NUM_CH-1:0]          fill_we,
    output logic [$clog2(WORDS)-1:0]   fill_idx,
    output logic [DATA_W-1:0]          fill_data,
    output logic [NUM_CH-1:0]          fill_done,
    input  logic                       wr_req,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       wr_ack,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic [DATA_W-1:0]          mem_wdata,
    input  logic [DATA_W-1:0]          mem_rdata
);

    localparam int IW  = $clog2(WORDS);
    localparam int OB  = off_bits(WORDS, DATA_W);
    localparam int BPW = DATA_W / 8;
    localparam int CW  = NUM_CH > 1 ? $clog2(NUM_CH) : 1;

    state_t              state;
    logic [NUM_CH-1:0]   grant;
    logic [ADDR_W-1:0]   base;
    logic [IW-1:0]       issue_cnt;
    logic [IW-1:0]       rcv_cnt;
    logic [MEM_LAT-1:0]  vsr;
    logic [NUM_CH-1:0]   arb_grant;
    logic [CW-1:0]       arb_idx;
    logic [ADDR_W-1:0]   sel_addr;
    logic                idle;
    logic                issuing;
    logic                wr_go;
    logic                take;
    logic                tap;

    rr_arbiter #(.NUM_CH(NUM_CH), .MODE(ARB_MODE)) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (miss_req),
        .accept    (take),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    always_comb begin
        sel_addr = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (arb_idx == CW'(c))
                sel_addr = miss_addr[c*ADDR_W +: ADDR_W];
    end

    assign idle    = state == IDLE;
    assign issuing = state == ISSUE;
    assign wr_go   = idle & wr_req;
    assign take    = idle & ~wr_req & (|miss_req);
    // the tap of the valid shift register marks a returning read beat
    assign tap     = vsr[MEM_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            grant     <= '0;
            base      <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            vsr       <= '0;
        end else begin
            vsr <= MEM_LAT'({vsr, issuing});
            if (tap)
                rcv_cnt <= rcv_cnt + 1'b1;
            case (state)
                IDLE: if (take) begin
                    state <= ISSUE;
                    grant <= arb_grant;
                    base  <= sel_addr & ~ADDR_W'((1 << OB) - 1);
                end
                ISSUE: begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (issue_cnt == IW'(WORDS - 1))
                        state <= DRAIN;
                end
                DRAIN: if (tap && rcv_cnt == IW'(WORDS - 1))
                    state <= DONE;
                DONE: state <= IDLE;
            endcase
        end
    end

    // counters wrap back to zero at the end of every block, so no reload on grant
    assign mem_en    = issuing | wr_go;
    assign mem_we    = wr_go;
    assign mem_addr  = issuing ? base + ADDR_W'(issue_cnt) * ADDR_W'(BPW) : wr_go ? wr_addr : '0;
    assign mem_wdata = wr_go ? wr_data : '0;
    assign wr_ack    = wr_go;
    assign fill_we   = tap ? grant : '0;
    assign fill_idx  = tap ? rcv_cnt : '0;
    assign fill_data = tap ? mem_rdata : '0;
    assign fill_done = (state == DONE) ? grant : '0;
    assign fsm_busy  = miss_req & ~fill_done;

endmodule
